// File: rtl/sle_pkg.sv
// Shared types for the SLE bank readback path: FSM state encoding and counter sizing.
package sle_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PAR     = 2'd2,
        DONE_ST = 2'd3
    } sle_state_e;

    // The counter must hold the value WIDTH itself, so it needs one extra code point.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sle_readback_shreg.sv
// Parallel-load shift register for the readback path; presents the next bit to send on bit_o.
module sle_readback_shreg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             bit_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
            assign bit_o   = shreg_q[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
            assign bit_o   = shreg_q[0];
        end
    endgenerate

    // Load has priority; the controller never asserts both in the same cycle anyway.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = d;
        end else if (shift) begin
            shreg_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/sle_bank_readback.sv
// Snapshots the SLE bank Q word on request and streams it out serially over a valid/ready
// handshake, optionally followed by an even-parity bit.
module sle_bank_readback
    import sle_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CAP_REQ,
    input  logic [WIDTH-1:0] BANK_Q,
    input  logic             SO_RDY,
    output logic             SO,
    output logic             SO_VLD,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = cnt_w(WIDTH);

    sle_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          par_q, par_d;
    logic          load;
    logic          shift;
    logic          cur_bit;

    sle_readback_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (CLK),
        .srst  (RST),
        .load  (load),
        .shift (shift),
        .d     (BANK_Q),
        .bit_o (cur_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        load    = 1'b0;
        shift   = 1'b0;
        SO      = 1'b0;
        SO_VLD  = 1'b0;
        BUSY    = 1'b1;
        DONE    = 1'b0;
        case (state_q)
            IDLE: begin
                BUSY = 1'b0;
                if (CAP_REQ) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH);
                    par_d   = (PARITY_EN != 0) ? ^BANK_Q : 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                SO_VLD = 1'b1;
                SO     = cur_bit;
                if (SO_RDY) begin
                    shift = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    // The transfer of the last data bit is the one that takes the count to zero.
                    if (cnt_q == CW'(1)) begin
                        state_d = (PARITY_EN != 0) ? PAR : DONE_ST;
                    end
                end
            end
            PAR: begin
                SO_VLD = 1'b1;
                SO     = par_q;
                if (SO_RDY) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

endmodule

// File: tb/tb_sle_bank_readback.sv
// Randomized self-checking bench for sle_bank_readback across three parameterisations.
module tb_sle_bank_readback;

    logic       clk = 1'b0;
    logic       rst;
    logic       cap  [3];
    logic [7:0] bank [3];
    logic       rdy  [3];
    logic       so   [3];
    logic       vld  [3];
    logic       busy [3];
    logic       done [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sle_bank_readback #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut_msb (
        .CLK(clk), .RST(rst), .CAP_REQ(cap[0]), .BANK_Q(bank[0]), .SO_RDY(rdy[0]),
        .SO(so[0]), .SO_VLD(vld[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    sle_bank_readback #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) dut_lsb (
        .CLK(clk), .RST(rst), .CAP_REQ(cap[1]), .BANK_Q(bank[1]), .SO_RDY(rdy[1]),
        .SO(so[1]), .SO_VLD(vld[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    sle_bank_readback #(.WIDTH(2), .MSB_FIRST(1), .PARITY_EN(0)) dut_w2 (
        .CLK(clk), .RST(rst), .CAP_REQ(cap[2]), .BANK_Q(bank[2][1:0]), .SO_RDY(rdy[2]),
        .SO(so[2]), .SO_VLD(vld[2]), .BUSY(busy[2]), .DONE(done[2])
    );

    function automatic int w_of(input int which);
        return (which == 2) ? 2 : 8;
    endfunction

    function automatic int msb_of(input int which);
        return (which == 1) ? 0 : 1;
    endfunction

    function automatic int par_of(input int which);
        return (which == 2) ? 0 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int which, input string tag);
        check({tag, "_vld"},  32'(vld[which]),  0);
        check({tag, "_so"},   32'(so[which]),   0);
        check({tag, "_busy"}, 32'(busy[which]), 0);
        check({tag, "_done"}, 32'(done[which]), 0);
    endtask

    // Reference: the frame is the captured word's bits in transmit order, then its even parity.
    task automatic run_frame(input int which, input logic [7:0] word, input bit rand_rdy,
                             input bit poke, input int stall_at, input int stall_len);
        int       w;
        int       n;
        int       idx;
        int       cyc;
        int       lows;
        int       stalled;
        bit       rdy_v;
        bit       exp_bits[$];
        int       wv;
        int       par;
        w   = w_of(which);
        wv  = int'(word) & ((1 << w) - 1);
        par = 0;
        exp_bits.delete();
        for (int i = 0; i < w; i++) begin
            int k;
            k = (msb_of(which) != 0) ? (w - 1 - i) : i;
            exp_bits.push_back(bit'((wv >> k) & 1));
            par = par ^ ((wv >> i) & 1);
        end
        if (par_of(which) != 0) exp_bits.push_back(bit'(par));
        n = exp_bits.size();

        @(negedge clk);
        check_idle(which, "pre");
        cap[which]  = 1'b1;
        bank[which] = word;
        rdy[which]  = 1'b1;
        @(negedge clk);
        cap[which] = 1'b0;
        idx = 0; cyc = 1; lows = 0; stalled = 0;
        while (idx < n) begin
            check("vld",  32'(vld[which]),  1);
            check("so",   32'(so[which]),   32'(exp_bits[idx]));
            check("busy", 32'(busy[which]), 1);
            check("done", 32'(done[which]), 0);
            rdy_v = rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
            if (idx == stall_at && stalled < stall_len) begin
                rdy_v = 1'b0;
                stalled++;
            end
            if (!rdy_v) lows++;
            rdy[which] = rdy_v;
            if (poke) begin
                cap[which]  = bit'($urandom_range(0, 1));
                bank[which] = 8'($urandom);
            end
            if (rdy_v) idx++;
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin
                check("timeout", 1, 0);
                break;
            end
        end
        rdy[which] = 1'b1;
        check("done_pulse", 32'(done[which]),  1);
        check("done_vld",   32'(vld[which]),   0);
        check("done_so",    32'(so[which]),    0);
        check("done_busy",  32'(busy[which]),  1);
        check("done_cycle", 32'(cyc), 32'(n + lows + 1));
        cap[which] = poke;
        @(negedge clk);
        cap[which] = 1'b0;
        check_idle(which, "post");
        @(negedge clk);
        check_idle(which, "post2");
        $display("[TB] frame dut%0d word=%02h bits=%0d stalls=%0d cycles=%0d", which, word, n, lows, cyc);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cap[i] = 1'b0; bank[i] = 8'h00; rdy[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        rst = 1'b0;

        run_frame(0, 8'hA5, 1'b0, 1'b0, -1, 0);
        run_frame(1, 8'h01, 1'b0, 1'b0, -1, 0);
        run_frame(0, 8'hF0, 1'b0, 1'b0, 2, 3);
        run_frame(0, 8'h6B, 1'b0, 1'b1, -1, 0);
        run_frame(2, 8'h02, 1'b0, 1'b0, -1, 0);

        // Reset mid-frame after four transfers: frame abandoned, no DONE.
        @(negedge clk);
        cap[0] = 1'b1; bank[0] = 8'hFF; rdy[0] = 1'b1;
        @(negedge clk);
        cap[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_vld", 32'(vld[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, "rst_mid");
        @(negedge clk);
        check_idle(0, "rst_mid2");
        $display("[TB] reset mid-frame dut0");

        // Reset and capture request together: reset wins.
        rst = 1'b1; cap[0] = 1'b1; bank[0] = 8'h81;
        @(negedge clk);
        rst = 1'b0; cap[0] = 1'b0;
        check_idle(0, "rst_cap");
        @(negedge clk);
        check_idle(0, "rst_cap2");
        $display("[TB] reset with capture dut0");

        run_frame(0, 8'h3C, 1'b0, 1'b0, -1, 0);

        for (int t = 0; t < 12; t++) begin
            run_frame(t % 3, 8'($urandom), 1'b1, bit'($urandom_range(0, 1)), -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
